sic1_host_loader: RTL
=====================

# sic1_host_loader

Host-side driver for the SIC-1 load/run pin protocol. It accepts a framed command byte stream over a valid/ready handshake (e.g. from a UART receiver) and turns it into the CPU's control strobes: data bus, set-PC, set-data and run. It sits between the host transport and the CPU's `ui_in` / `uio_in[3:0]` pins. It guarantees one-cycle strobes and never issues loads while the CPU may still be executing.

## Interface
- `STOP_WAIT`, default 8: cycles to hold off after dropping run before any load strobe. Must be ≥ 7, which covers the longest CPU instruction (6 states) plus margin.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_data`  in  8  command/payload byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts a byte this cycle; a transfer is `in_valid & in_ready`.
- `cpu_data`  out  8  drives CPU `ui_in`.
- `cpu_set_pc`  out  1  drives `uio_in[2]`.
- `cpu_set_data`  out  1  drives `uio_in[3]`.
- `cpu_run`  out  1  drives `uio_in[0]`.
- `busy`  out  1  loader is not in IDLE.
- `err`  out  1  sticky: an unknown opcode was received.

## Operation
- Opcodes:
  - `0xA0 addr`: set PC.
  - `0xA1 len d0..d(len-1)`: write `len` bytes at consecutive addresses. The CPU auto-increments PC.
  - `0xA2`: run.
  - `0xA3`: stop.
- States:
  - IDLE: wait for an opcode.
  - DRAIN: stop-wait countdown.
  - GET_ADDR: wait for the address byte.
  - GET_LEN: wait for the length byte.
  - DATA: pass payload bytes through.
- IDLE transitions:
  - `0xA0` → GET_ADDR, or DRAIN first if `cpu_run`=1.
  - `0xA1` → GET_LEN, or DRAIN first if `cpu_run`=1.
  - `0xA2` sets `cpu_run`=1 and stays in IDLE.
  - `0xA3` clears `cpu_run` and enters DRAIN.
  - Any other byte: set `err`, drop the byte, stay in IDLE.
- DRAIN:
  - `cpu_run` is 0 and `in_ready` is 0.
  - A counter loads `STOP_WAIT-1` and decrements.
  - At 0, go to the pending target: GET_ADDR, GET_LEN, or IDLE (for `0xA3`).
- GET_ADDR: on transfer, `cpu_data`←byte and `cpu_set_pc` pulses. Then → IDLE.
- GET_LEN:
  - On transfer, the remaining count←byte.
  - Count 0 → IDLE with no strobes. Otherwise → DATA.
- DATA:
  - Each transfer: `cpu_data`←byte, `cpu_set_data` pulses, count decrements.
  - The last byte → IDLE.
  - Counter is 8-bit, so `len` is 1..255.
- `in_ready`=1 in IDLE, GET_ADDR, GET_LEN and DATA; 0 in DRAIN.
- Reset values: all outputs 0, `cpu_data`=0x00, state IDLE, counters 0, `err`=0.
- Reset mid-frame:
  - The frame is abandoned and any strobe is dropped.
  - The next byte after reset is parsed as an opcode.
- Run is never raised implicitly. Loads after a stop leave `cpu_run`=0 until the next `0xA2`.

## Timing
- All outputs are registered.
- A strobe asserts the cycle after the accepting transfer, for exactly 1 cycle.
- `cpu_data` holds its value until the next update, so it is stable during the strobe.
- Back-to-back payload bytes give strobes on consecutive cycles, which the CPU accepts, at full throughput.
- A stalled source (`in_valid`=0) gives no strobe that cycle.
- `cpu_set_pc` and `cpu_set_data` are never high in the same cycle.
- `0xA2`: `cpu_run` rises the cycle after the transfer.
- `0xA3`, or a load while running:
  - `cpu_run` falls the cycle after the opcode.
  - `in_ready` is low for exactly `STOP_WAIT` cycles.
  - The first load strobe comes at least `STOP_WAIT`+1 cycles after run fell.
- `busy` = state≠IDLE, registered.

## Structure
- Shared package `sic1_pkg`:
  - opcode constants `OP_SETPC`=0xA0, `OP_LOAD`=0xA1, `OP_RUN`=0xA2, `OP_STOP`=0xA3;
  - the loader state enum;
  - pin index constants `PIN_RUN`=0, `PIN_SET_PC`=2, `PIN_SET_DATA`=3, shared with the CPU top.
- Single module, no sub-modules. The DRAIN counter is inline.

## Test plan
- `A0 10` → one `cpu_set_pc` pulse with `cpu_data`=0x10, the cycle after the `10` transfer. `busy` returns to 0.
- `A1 03 11 22 33`, streamed with no gaps → `cpu_set_data` high for 3 consecutive cycles with `cpu_data` 0x11, 0x22, 0x33. No `cpu_set_pc`.
- Same load with `in_valid` gaps → exactly 3 single-cycle strobes, with no duplicates during stalls.
- `A2` then `A1 01 55`:
  - `cpu_run` rises, then falls after the `A1`;
  - `in_ready` is low for 8 cycles;
  - the strobe for 0x55 comes ≥9 cycles after run fell;
  - `cpu_run` stays 0.
- `A1 00` → no strobes, back to IDLE. A following `7F` → `err`=1, no strobes, later opcodes still work.
- Reset asserted after `A1 05 01` → all outputs 0. Then `A0 20` → one `cpu_set_pc` with `cpu_data`=0x20.

Source files
------------

// File: rtl/sic1_pkg.sv
// Shared SIC-1 definitions: host loader opcodes, loader FSM states and the
// CPU control-pin indices used by both the loader and the CPU top.
package sic1_pkg;

    localparam logic [7:0] OP_SETPC = 8'hA0;
    localparam logic [7:0] OP_LOAD  = 8'hA1;
    localparam logic [7:0] OP_RUN   = 8'hA2;
    localparam logic [7:0] OP_STOP  = 8'hA3;

    localparam int PIN_RUN      = 0;
    localparam int PIN_SET_PC   = 2;
    localparam int PIN_SET_DATA = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_GET_ADDR,
        ST_GET_LEN,
        ST_DATA
    } loader_state_e;

endpackage

// File: rtl/sic1_host_loader.sv
// Converts a framed host byte stream into SIC-1 load/run strobes, holding
// off loads for STOP_WAIT cycles after run drops so the CPU can settle.
module sic1_host_loader
    import sic1_pkg::*;
#(
    parameter int STOP_WAIT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] cpu_data,
    output logic       cpu_set_pc,
    output logic       cpu_set_data,
    output logic       cpu_run,
    output logic       busy,
    output logic       err
);

    localparam int DW = $clog2(STOP_WAIT);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(STOP_WAIT - 1);

    loader_state_e state_q, state_d, tgt_q, tgt_d;
    logic [DW-1:0] drain_q, drain_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    data_q, data_d;
    logic          set_pc_q, set_pc_d;
    logic          set_data_q, set_data_d;
    logic          run_q, run_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          ready_q, ready_d;
    logic          xfer;

    assign xfer = in_valid && ready_q;

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        drain_d    = drain_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        set_pc_d   = 1'b0;
        set_data_d = 1'b0;
        run_d      = run_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    case (in_data)
                        OP_SETPC, OP_LOAD: begin
                            tgt_d = (in_data == OP_SETPC) ? ST_GET_ADDR : ST_GET_LEN;
                            // A load while running must first stop the CPU and wait.
                            if (run_q) begin
                                run_d   = 1'b0;
                                drain_d = DRAIN_LOAD;
                                state_d = ST_DRAIN;
                            end else begin
                                state_d = tgt_d;
                            end
                        end
                        OP_RUN: run_d = 1'b1;
                        OP_STOP: begin
                            run_d   = 1'b0;
                            drain_d = DRAIN_LOAD;
                            tgt_d   = ST_IDLE;
                            state_d = ST_DRAIN;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) state_d = tgt_q;
                else               drain_d = drain_q - 1'b1;
            end
            ST_GET_ADDR: begin
                if (xfer) begin
                    data_d   = in_data;
                    set_pc_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_GET_LEN: begin
                if (xfer) begin
                    cnt_d   = in_data;
                    state_d = (in_data == 8'd0) ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    data_d     = in_data;
                    set_data_d = 1'b1;
                    cnt_d      = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d != ST_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tgt_q      <= ST_IDLE;
            drain_q    <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            set_pc_q   <= 1'b0;
            set_data_q <= 1'b0;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            drain_q    <= drain_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            set_pc_q   <= set_pc_d;
            set_data_q <= set_data_d;
            run_q      <= run_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
        end
    end

    assign in_ready     = ready_q;
    assign cpu_data     = data_q;
    assign cpu_set_pc   = set_pc_q;
    assign cpu_set_data = set_data_q;
    assign cpu_run      = run_q;
    assign busy         = busy_q;
    assign err          = err_q;

endmodule
